// File: rtl/demuxi_1to2.sv
// Registered 1-to-2 stream demultiplexer: steers each accepted word to channel s,
// with a one-entry output register, valid/ready handshake and delivery counter per channel.
module demuxi_1to2 #(
  parameter int unsigned W  = 3,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s,
  input  logic [W-1:0]  d,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  z0,
  output logic          z0_valid,
  input  logic          z0_ready,
  output logic [W-1:0]  z1,
  output logic          z1_valid,
  input  logic          z1_ready,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1
);

  logic [W-1:0]  z0_q, z0_d, z1_q, z1_d;
  logic          z0_valid_q, z0_valid_d, z1_valid_q, z1_valid_d;
  logic [CW-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic          sel_valid, sel_ready, accept, load0, load1, drain0, drain1;

  always_comb begin
    // Only the selected channel gates the input: head-of-line blocking is intended.
    sel_valid  = s ? z1_valid_q : z0_valid_q;
    sel_ready  = s ? z1_ready : z0_ready;
    in_ready   = !sel_valid || sel_ready;
    accept     = in_valid && in_ready;
    load0      = accept && !s;
    load1      = accept && s;
    drain0     = z0_valid_q && z0_ready;
    drain1     = z1_valid_q && z1_ready;

    z0_d       = load0 ? d : z0_q;
    z1_d       = load1 ? d : z1_q;
    z0_valid_d = load0 || (z0_valid_q && !z0_ready);
    z1_valid_d = load1 || (z1_valid_q && !z1_ready);
    cnt0_d     = cnt0_q + {{(CW-1){1'b0}}, drain0};
    cnt1_d     = cnt1_q + {{(CW-1){1'b0}}, drain1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z0_q       <= '0;
      z1_q       <= '0;
      z0_valid_q <= 1'b0;
      z1_valid_q <= 1'b0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else begin
      z0_q       <= z0_d;
      z1_q       <= z1_d;
      z0_valid_q <= z0_valid_d;
      z1_valid_q <= z1_valid_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
    end
  end

  assign z0       = z0_q;
  assign z1       = z1_q;
  assign z0_valid = z0_valid_q;
  assign z1_valid = z1_valid_q;
  assign cnt0     = cnt0_q;
  assign cnt1     = cnt1_q;

endmodule
